// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: register offsets,
// status bit positions, receive FSM encoding and a count-saturation helper.
package ps2_kbd_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int AVAIL = 7;
  localparam int OVR   = 6;
  localparam int PERR  = 5;
  localparam int FERR  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // The status register only has a 4-bit count field.
  function automatic logic [3:0] sat_count(input logic [31:0] c);
    return (c > 32'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous 8-bit scan-code FIFO; the head is always visible on dout.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// Receive-only PS/2 keyboard port with scan-code FIFO and CPU register interface.
// Optional clock inhibit while the FIFO is full: define PS2_KBD_INHIBIT_EN.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] a,
  input  logic [7:0] di,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       kclk,
  input  logic       kd,
  output logic       kclk_oe
);

  import ps2_kbd_pkg::*;

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FILT_W  = $clog2(FILTER_LEN + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYC + 1);

  // Two-flop synchronisers, index 0 = kclk, index 1 = kd.
  logic [1:0] pin_raw;
  logic [1:0] pin_sync;
  assign pin_raw = {kd, kclk};

  for (genvar gi = 0; gi < 2; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_reg <= 1'b1;
        s2_reg <= 1'b1;
      end else begin
        s1_reg <= pin_raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign pin_sync[gi] = s2_reg;
  end

  logic kclk_s;
  logic kd_s;
  assign kclk_s = pin_sync[0];
  assign kd_s   = pin_sync[1];

  logic              filt_reg;
  logic [FILT_W-1:0] filt_cnt_reg;
  logic              fall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
      fall_reg     <= 1'b0;
    end else begin
      fall_reg <= 1'b0;
      if (kclk_s == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FILT_W'(FILTER_LEN - 1)) begin
        filt_reg     <= kclk_s;
        filt_cnt_reg <= '0;
        fall_reg     <= ~kclk_s;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
      end
    end
  end

  rx_state_t       state_reg, state_next;
  logic [2:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic            par_reg, par_next;
  logic [TO_W-1:0] to_reg, to_next;
  logic            push_reg, push_next;
  logic            perr_set_reg, perr_set_next;
  logic            ferr_set_reg, ferr_set_next;
  logic            parity_ok;
  logic            stop_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_reg      <= 1'b0;
      to_reg       <= '0;
      push_reg     <= 1'b0;
      perr_set_reg <= 1'b0;
      ferr_set_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      par_reg      <= par_next;
      to_reg       <= to_next;
      push_reg     <= push_next;
      perr_set_reg <= perr_set_next;
      ferr_set_reg <= ferr_set_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    par_next      = par_reg;
    to_next       = '0;
    push_next     = 1'b0;
    perr_set_next = 1'b0;
    ferr_set_next = 1'b0;
    parity_ok     = (^shift_reg) ^ par_reg;
    stop_ok       = kd_s;

    if (state_reg != IDLE && !fall_reg) begin
      to_next = to_reg + TO_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (fall_reg && !kd_s) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (fall_reg) begin
          shift_next   = {kd_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (fall_reg) begin
          par_next   = kd_s;
          state_next = STOP;
        end
      end
      STOP: begin
        if (fall_reg) begin
          push_next     = parity_ok & stop_ok;
          perr_set_next = ~parity_ok;
          ferr_set_next = ~stop_ok;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A stalled keyboard must not wedge the receiver mid-frame.
    if (state_reg != IDLE && !fall_reg && to_reg == TO_W'(TIMEOUT_CYC)) begin
      state_next = IDLE;
      to_next    = '0;
    end
  end

  logic [7:0]         fifo_head;
  logic               fifo_empty;
  logic               fifo_full;
  logic [FIFO_CW-1:0] fifo_count;
  logic               fifo_pop;
  logic               rd_cyc;
  logic               wr_cyc;
  logic               stat_clr;

  assign rd_cyc   = ce & cs & rw;
  assign wr_cyc   = ce & cs & ~rw;
  assign fifo_pop = rd_cyc & (a == REG_DATA) & ~fifo_empty;
  assign stat_clr = wr_cyc & (a == REG_STAT);

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_reg),
    .pop   (fifo_pop),
    .din   (shift_reg),
    .dout  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  logic ovr_reg;
  logic perr_reg;
  logic ferr_reg;
  logic irq_en_reg;
  logic irq_reg;

  // Set terms are OR'd after the clear so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovr_reg    <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      ovr_reg  <= (push_reg & fifo_full & ~fifo_pop) | (ovr_reg & ~(stat_clr & di[OVR]));
      perr_reg <= perr_set_reg | (perr_reg & ~(stat_clr & di[PERR]));
      ferr_reg <= ferr_set_reg | (ferr_reg & ~(stat_clr & di[FERR]));
      if (wr_cyc && a == REG_CTRL) irq_en_reg <= di[0];
      irq_reg <= irq_en_reg & ~fifo_empty;
    end
  end

  logic [7:0] stat;
  always_comb begin
    stat        = '0;
    stat[AVAIL] = ~fifo_empty;
    stat[OVR]   = ovr_reg;
    stat[PERR]  = perr_reg;
    stat[FERR]  = ferr_reg;
    stat[3:0]   = sat_count(32'(fifo_count));
  end

  always_comb begin
    dout = 8'h00;
    case (a)
      REG_DATA: dout = fifo_empty ? 8'h00 : fifo_head;
      REG_STAT: dout = stat;
      REG_CTRL: dout = {7'b0, irq_en_reg};
      default:  dout = 8'h00;
    endcase
  end

  assign irq = irq_reg;

`ifdef PS2_KBD_INHIBIT_EN
  assign kclk_oe = fifo_full & (state_reg == IDLE);
`else
  assign kclk_oe = 1'b0;
`endif

  logic unused_di;
  assign unused_di = ^{di[7], di[3:1]};

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: bit-bangs PS/2 frames and checks
// scan codes against a scoreboard queue plus status/irq/kclk_oe constants.
module tb_ps2_kbd_rx;

  localparam int TO_CYC = 1000;
  localparam int HALF   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic       cs = 1'b0;
  logic       rw = 1'b1;
  logic [1:0] a = 2'd0;
  logic [7:0] di = 8'h00;
  logic [7:0] dout;
  logic       irq;
  logic       kclk = 1'b1;
  logic       kd = 1'b1;
  logic       kclk_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  always #5 clk = ~clk;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (8),
    .FILTER_LEN  (4),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ce      (ce),
    .cs      (cs),
    .rw      (rw),
    .a       (a),
    .di      (di),
    .dout    (dout),
    .irq     (irq),
    .kclk    (kclk),
    .kd      (kd),
    .kclk_oe (kclk_oe)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b1; a = addr; ce = 1'b1;
    #1 d = dout;
    @(posedge clk);
    #1 cs = 1'b0; ce = 1'b0;
    $display("read  a=%0d -> %h", addr, d);
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; rw = 1'b0; a = addr; di = d; ce = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; ce = 1'b0; rw = 1'b1;
    $display("write a=%0d <- %h", addr, d);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      kd = bits[i];
      repeat (HALF) @(posedge clk);
      kclk = 1'b0;
      repeat (HALF) @(posedge clk);
      kclk = 1'b1;
    end
    repeat (HALF) @(posedge clk);
    kd = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic stop);
    logic [10:0] v;
    v = {stop, (~^data) ^ bad_par, data, 1'b0};
    send_bits(v, 11);
    $display("frame %h sent (bad_par=%0b stop=%0b)", data, bad_par, stop);
  endtask

  task automatic read_expect_sb();
    logic [7:0] got;
    logic [7:0] exp;
    bus_read(2'd0, got);
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_data: got %h but scoreboard is empty", got);
    end else begin
      exp = sb_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL sb_data: got %h expected %h", got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_read(2'(r), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h expected 00", r, d);
      end
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0 || kclk_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: irq=%b kclk_oe=%b expected 0 0", irq, kclk_oe);
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] d;
    bus_write(2'd2, 8'h01);
    bus_read(2'd2, d);
    checks++;
    if (d !== 8'h01) begin errors++; $display("FAIL ctrl_rb: got %h expected 01", d); end
    send_frame(8'h1C, 1'b0, 1'b1);
    sb_q.push_back(8'h1C);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL good_stat: got %h expected 81", d); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL good_irq: got %b expected 1", irq); end
    read_expect_sb();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL good_stat_after: got %h expected 00", d); end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL good_irq_after: got %b expected 0", irq); end
  endtask

  task automatic test_parity_err();
    logic [7:0] d;
    send_frame(8'h1C, 1'b1, 1'b1);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h20) begin errors++; $display("FAIL perr_stat: got %h expected 20", d); end
    bus_write(2'd1, 8'h20);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL perr_clr: got %h expected 00", d); end
  endtask

`ifndef PS2_KBD_INHIBIT_EN
  task automatic test_overflow();
    logic [7:0] d;
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1);
      if (i <= 8) sb_q.push_back(8'(i));
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'hC8) begin errors++; $display("FAIL ovr_stat: got %h expected C8", d); end
    checks++;
    if (kclk_oe !== 1'b0) begin errors++; $display("FAIL ovr_oe: got %b expected 0", kclk_oe); end
    for (int i = 0; i < 8; i++) read_expect_sb();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h40) begin errors++; $display("FAIL ovr_sticky: got %h expected 40", d); end
    bus_write(2'd1, 8'h40);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL ovr_clr: got %h expected 00", d); end
  endtask
`else
  task automatic test_inhibit();
    logic [7:0] d;
    for (int i = 1; i <= 8; i++) begin
      send_frame(8'(i), 1'b0, 1'b1);
      sb_q.push_back(8'(i));
    end
    @(negedge clk);
    checks++;
    if (kclk_oe !== 1'b1) begin errors++; $display("FAIL inh_full: got %b expected 1", kclk_oe); end
    read_expect_sb();
    checks++;
    if (kclk_oe !== 1'b0) begin errors++; $display("FAIL inh_release: got %b expected 0", kclk_oe); end
    for (int i = 0; i < 7; i++) read_expect_sb();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL inh_stat: got %h expected 00", d); end
  endtask
`endif

  task automatic test_timeout();
    logic [7:0] d;
    send_bits(11'b000_0000_1010, 5);
    repeat (TO_CYC + 10) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    sb_q.push_back(8'h5A);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL to_stat: got %h expected 81", d); end
    read_expect_sb();
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h00) begin errors++; $display("FAIL to_empty: got %h expected 00", d); end
  endtask

  task automatic test_ferr_reset();
    logic [7:0] d;
    send_frame(8'hF0, 1'b0, 1'b0);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h10) begin errors++; $display("FAIL ferr_stat: got %h expected 10", d); end
    send_bits(11'b000_0011_0110, 5);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      bus_read(2'(r), d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL midreset_reg%0d: got %h expected 00", r, d);
      end
    end
    send_frame(8'h1C, 1'b0, 1'b1);
    sb_q.push_back(8'h1C);
    bus_read(2'd1, d);
    checks++;
    if (d !== 8'h81) begin errors++; $display("FAIL postreset_stat: got %h expected 81", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL postreset_irq: got %b expected 0", irq); end
    read_expect_sb();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
`ifndef PS2_KBD_INHIBIT_EN
    test_overflow();
`else
    test_inhibit();
`endif
    test_timeout();
    test_ferr_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
